// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
// One Full_Adder is stepped over WIDTH clock cycles, LSB first. Operands are
// captured on an accepted start, shifted right once per RUN cycle, and the
// result bits enter the partial-sum register at its MSB. After WIDTH RUN
// cycles, sum/cout are loaded and done pulses for one cycle.

// Single-bit full adder used as the serial datapath.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] ps_shift;

  Full_Adder u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Partial sum with this cycle's bit at the MSB; written as shift/or so
  // WIDTH = 1 needs no special-cased slice.
  always_comb begin
    ps_shift = (ps_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  end

  // Next-state and datapath control; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ps_d    = ps_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        ps_d    = ps_shift;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = ps_shift;
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ps_q    <= ps_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Status decoded straight from registered state.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl, WIDTH = 8 and WIDTH = 1.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_chk = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference timing model: 0 idle, 1 run, 2 done.
  int         m8_ph = 0, m8_cnt = 0, acc8 = 0, cmp8 = 0;
  int         m1_ph = 0, m1_cnt = 0, acc1 = 0, cmp1 = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] h8 = '0;
  logic [1:0] h1 = '0;
  int         dn8 = 0, dn1 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_ph <= 0;
      m8_cnt <= 0;
      q8.delete();
    end else begin
      case (m8_ph)
        0: if (start8) begin
          q8.push_back({1'b0, a8} + {1'b0, b8} + 9'(cin8));
          acc8 <= acc8 + 1;
          m8_cnt <= 0;
          m8_ph <= 1;
        end
        1: begin
          m8_cnt <= m8_cnt + 1;
          if (m8_cnt == 7) begin
            m8_ph <= 2;
            cmp8 <= cmp8 + 1;
          end
        end
        default: m8_ph <= 0;
      endcase
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_ph <= 0;
      m1_cnt <= 0;
      q1.delete();
    end else begin
      case (m1_ph)
        0: if (start1) begin
          q1.push_back({1'b0, a1} + {1'b0, b1} + 2'(cin1));
          acc1 <= acc1 + 1;
          m1_cnt <= 0;
          m1_ph <= 1;
        end
        1: begin
          m1_cnt <= m1_cnt + 1;
          if (m1_cnt == 0) begin
            m1_ph <= 2;
            cmp1 <= cmp1 + 1;
          end
        end
        default: m1_ph <= 0;
      endcase
    end
  end

  // Per-cycle scoreboard checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      h8 <= '0;
    end else begin
      chk("busy8", 64'(busy8), 64'(m8_ph == 1));
      chk("done8", 64'(done8), 64'(m8_ph == 2));
      if (done8) dn8 <= dn8 + 1;
      if (m8_ph == 2) begin
        if (q8.size() == 0) chk("q8_underflow", 64'(1), 64'(0));
        else begin
          chk("result8", 64'({cout8, sum8}), 64'(q8[0]));
          h8 <= q8.pop_front();
        end
      end else begin
        chk("hold8", 64'({cout8, sum8}), 64'(h8));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      h1 <= '0;
    end else begin
      chk("busy1", 64'(busy1), 64'(m1_ph == 1));
      chk("done1", 64'(done1), 64'(m1_ph == 2));
      if (done1) dn1 <= dn1 + 1;
      if (m1_ph == 2) begin
        if (q1.size() == 0) chk("q1_underflow", 64'(1), 64'(0));
        else begin
          chk("result1", 64'({cout1, sum1}), 64'(q1[0]));
          h1 <= q1.pop_front();
        end
      end else begin
        chk("hold1", 64'({cout1, sum1}), 64'(h1));
      end
    end
  end

  task automatic wait_idle8();
    int t = 0;
    while (m8_ph != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("timeout8", 64'(1), 64'(0));
  endtask

  task automatic wait_idle1();
    int t = 0;
    while (m1_ph != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("timeout1", 64'(1), 64'(0));
  endtask

  // Called on a falling edge: one-cycle start pulse, then wait for IDLE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8();
  endtask

  initial begin
    int nb;
    int base;
    int guard;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'(0));
    chk("rst_done8", 64'(done8), 64'(0));
    chk("rst_res8", 64'({cout8, sum8}), 64'(0));
    chk("rst_busy1", 64'(busy1), 64'(0));
    chk("rst_res1", 64'({cout1, sum1}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Zero operands, explicit latency count.
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    nb = 0;
    while (busy8 && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    chk("lat_busy_cycles", 64'(nb), 64'(8));
    chk("lat_done", 64'(done8), 64'(1));
    chk("zero_sum", 64'({cout8, sum8}), 64'(9'h000));
    wait_idle8();

    // Directed operand patterns.
    op8(8'hFF, 8'h01, 1'b0);
    chk("ff_01", 64'({cout8, sum8}), 64'(9'h100));
    op8(8'hA5, 8'h5A, 1'b1);
    chk("a5_5a_c", 64'({cout8, sum8}), 64'(9'h100));
    op8(8'h12, 8'h34, 1'b0);
    chk("12_34", 64'({cout8, sum8}), 64'(9'h046));

    // Start held high, operands changing every cycle: accepts at E0, E10, E20.
    base = acc8;
    repeat (25) begin
      start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("held_accepts", 64'(acc8 - base), 64'(3));
    wait_idle8();

    // Start pulses during RUN are ignored; sum holds until completion.
    op8(8'h12, 8'h34, 1'b0);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    @(negedge clk);
    base = acc8;
    repeat (3) begin
      start8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
    end
    chk("run_ignore_acc", 64'(acc8 - base), 64'(0));
    chk("run_hold_sum", 64'(sum8), 64'(8'h46));
    wait_idle8();
    chk("run_new_res", 64'({cout8, sum8}), 64'(9'h101));

    // Asynchronous reset between E4 and E5.
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy", 64'(busy8), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy8), 64'(0));
    chk("arst_done", 64'(done8), 64'(0));
    chk("arst_sum", 64'(sum8), 64'(0));
    chk("arst_cout", 64'(cout8), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op8(8'h12, 8'h34, 1'b0);
    chk("post_rst_res", 64'({cout8, sum8}), 64'(9'h046));

    // Random regression, WIDTH = 8.
    base = acc8;
    guard = 0;
    while (acc8 - base < 1000 && guard < 30000) begin
      start8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
      guard++;
    end
    start8 = 1'b0;
    if (guard >= 30000) chk("rand8_budget", 64'(1), 64'(0));
    wait_idle8();

    // Random regression, WIDTH = 1.
    base = acc1;
    guard = 0;
    while (acc1 - base < 1000 && guard < 30000) begin
      start1 = ($urandom_range(0, 3) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      @(negedge clk);
      guard++;
    end
    start1 = 1'b0;
    if (guard >= 30000) chk("rand1_budget", 64'(1), 64'(0));
    wait_idle1();
    @(negedge clk);

    chk("done_count8", 64'(dn8), 64'(cmp8));
    chk("done_count1", 64'(dn1), 64'(cmp1));
    chk("aborted8", 64'(acc8 - cmp8), 64'(1));
    chk("aborted1", 64'(acc1 - cmp1), 64'(0));
    chk("q8_drained", 64'(q8.size()), 64'(0));
    chk("q1_drained", 64'(q1.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
